mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0; 0 = round-robin on contention, 1 = dmem always wins contention.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_address  in  16  instruction fetch address (lc3b_word).
REQ-006 imem_action_stb, imem_action_cyc  in  1 each  instruction-side request strobe / cycle-valid.
REQ-007 imem_rdata  out  128  returned line (lc3b_data); imem_resp, imem_retry  out  1 each.
REQ-008 dmem_address, dmem_wdata  in  16 each  data-side address / write data.
REQ-009 dmem_action_stb, dmem_action_cyc, dmem_write  in  1 each; dmem_byte_enable  in  2 (lc3b_mem_wmask).
REQ-010 dmem_rdata  out  128; dmem_resp, dmem_retry  out  1 each.
REQ-011 mem_address, mem_wdata  out  16 each; mem_byte_enable  out  2; mem_write, mem_action_stb, mem_action_cyc  out  1 each  shared memory port.
REQ-012 mem_rdata  in  128; mem_resp, mem_retry  in  1 each  shared-port response.

Function
REQ-013 Master request = action_stb & action_cyc, sampled at clk.
REQ-014 FSM states IDLE, GRANT_I, GRANT_D; reset state IDLE.
REQ-015 IDLE: only imem requests -> GRANT_I; only dmem -> GRANT_D; none -> stay.
REQ-016 IDLE, both request: FIXED_PRIORITY=1 -> GRANT_D; else grant master not in last_grant register (reset value: I, so dmem wins first contention).
REQ-017 Grant is registered: first shared-port strobe one cycle after request seen in IDLE (1-cycle arbitration latency).
REQ-018 In GRANT_x: mem_address/wdata/byte_enable/write/stb/cyc driven from granted master; imem side forces mem_write=0, mem_byte_enable=2'b11, mem_wdata=0.
REQ-019 In IDLE: mem_action_stb=0, mem_action_cyc=0, mem_write=0, other mem outputs 0.
REQ-020 imem_rdata and dmem_rdata both continuously equal mem_rdata (no register); validity signalled only by resp.
REQ-021 Granted master: resp = mem_resp, retry = mem_retry, same cycle. Non-granted master: resp=0, retry=0 always.
REQ-022 mem_resp in GRANT_x -> next state IDLE, last_grant <= x; one idle turnaround cycle between transactions.
REQ-023 mem_retry in GRANT_x -> next state IDLE, last_grant <= x (bus released; other master may win).
REQ-024 Granted master drops cyc before resp (abort) -> mem stb/cyc deassert same cycle (combinational pass-through), next state IDLE, last_grant unchanged.
REQ-025 mem_resp and mem_retry both high: resp takes precedence; retry suppressed to master.
REQ-026 mem_resp/mem_retry while IDLE ignored; no master sees them.
REQ-027 Granted master's address/data changes mid-transaction pass through unchanged; arbiter does not latch request fields.

Reset
REQ-028 reset=1 at any edge: state <= IDLE, last_grant <= I; takes priority over all transitions, including mid-transaction.
REQ-029 While in reset and cycle after: all mem_* outputs 0, all resp/retry outputs 0.

Structure
REQ-030 lc3b_word, lc3b_data (128-bit), lc3b_mem_wmask (2-bit) and arbiter state enum (arb_state_t) reside in lc3b_types package.
REQ-031 Single module, no sub-modules; FSM next-state and output mux as separate combinational processes.

Verification
REQ-032 Solo imem: req addr 0x0040 at cycle 0 -> mem_stb=1, mem_address=0x0040, mem_write=0 at cycle 1; mem_resp at cycle 3 with 0x...BEEF -> imem_resp=1, imem_rdata=0x...BEEF cycle 3; IDLE cycle 4.
REQ-033 Contention after reset: both request cycle 0 -> GRANT_D (dmem 0x1000, write=1, wdata 0x5A5A, be 2'b01 on mem); after resp, I granted next; then repeat contention -> D again (alternation).
REQ-034 FIXED_PRIORITY=1, both requesting continuously, ack every transaction -> only dmem granted until dmem drops request.
REQ-035 mem_retry during GRANT_I while dmem waiting -> imem_retry=1 for one cycle, dmem granted next arbitration.
REQ-036 reset asserted while GRANT_D with stb high -> next cycle all mem_* 0, dmem_resp=0; later mem_resp ignored.
REQ-037 dmem drops cyc during GRANT_D -> mem_cyc=0 same cycle, IDLE next, pending imem granted after.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory types and the arbiter state encoding.
package lc3b_types;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned WMASK_W = 2;

  typedef logic [WORD_W-1:0]  lc3b_word;
  typedef logic [DATA_W-1:0]  lc3b_data;
  typedef logic [WMASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } master_t;

  // Request fields presented on the shared memory port.
  typedef struct packed {
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask byte_enable;
    logic          write;
    logic          stb;
    logic          cyc;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master (instruction/data) arbiter onto one shared memory port.
// Round-robin or fixed dmem priority on contention; grant is registered.
module mem_port_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic         clk,
  input  logic         reset,

  input  logic [15:0]  imem_address,
  input  logic         imem_action_stb,
  input  logic         imem_action_cyc,
  output logic [127:0] imem_rdata,
  output logic         imem_resp,
  output logic         imem_retry,

  input  logic [15:0]  dmem_address,
  input  logic [15:0]  dmem_wdata,
  input  logic         dmem_action_stb,
  input  logic         dmem_action_cyc,
  input  logic         dmem_write,
  input  logic [1:0]   dmem_byte_enable,
  output logic [127:0] dmem_rdata,
  output logic         dmem_resp,
  output logic         dmem_retry,

  output logic [15:0]  mem_address,
  output logic [15:0]  mem_wdata,
  output logic [1:0]   mem_byte_enable,
  output logic         mem_write,
  output logic         mem_action_stb,
  output logic         mem_action_cyc,
  input  logic [127:0] mem_rdata,
  input  logic         mem_resp,
  input  logic         mem_retry
);
  import lc3b_types::*;

  arb_state_t state, state_next;
  master_t    last_grant, last_grant_next;
  mem_req_t   bus;
  logic       imem_req, dmem_req, dmem_wins;

  assign imem_req  = imem_action_stb & imem_action_cyc;
  assign dmem_req  = dmem_action_stb & dmem_action_cyc;
  assign dmem_wins = (FIXED_PRIORITY != 0) || (last_grant == LAST_I);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= LAST_I;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Arbitration; a completed or retried transaction records its owner,
  // an aborted one (cyc dropped) leaves the round-robin pointer alone.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (imem_req && dmem_req) state_next = dmem_wins ? GRANT_D : GRANT_I;
        else if (dmem_req)        state_next = GRANT_D;
        else if (imem_req)        state_next = GRANT_I;
      end
      GRANT_I: begin
        if (mem_resp || mem_retry) begin
          state_next      = IDLE;
          last_grant_next = LAST_I;
        end else if (!imem_action_cyc) begin
          state_next = IDLE;
        end
      end
      GRANT_D: begin
        if (mem_resp || mem_retry) begin
          state_next      = IDLE;
          last_grant_next = LAST_D;
        end else if (!dmem_action_cyc) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Port mux: granted master passes straight through; reset blanks everything.
  always_comb begin
    bus        = '0;
    imem_resp  = 1'b0;
    imem_retry = 1'b0;
    dmem_resp  = 1'b0;
    dmem_retry = 1'b0;
    if (!reset) begin
      case (state)
        GRANT_I: begin
          bus = '{address: imem_address, wdata: 16'h0000, byte_enable: 2'b11,
                  write: 1'b0, stb: imem_action_stb, cyc: imem_action_cyc};
          imem_resp  = mem_resp;
          imem_retry = mem_retry & ~mem_resp;
        end
        GRANT_D: begin
          bus = '{address: dmem_address, wdata: dmem_wdata, byte_enable: dmem_byte_enable,
                  write: dmem_write, stb: dmem_action_stb, cyc: dmem_action_cyc};
          dmem_resp  = mem_resp;
          dmem_retry = mem_retry & ~mem_resp;
        end
        default: ;
      endcase
    end
  end

  assign mem_address     = bus.address;
  assign mem_wdata       = bus.wdata;
  assign mem_byte_enable = bus.byte_enable;
  assign mem_write       = bus.write;
  assign mem_action_stb  = bus.stb;
  assign mem_action_cyc  = bus.cyc;

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and fixed-priority instances on
// shared stimulus, checked each cycle against a bus-ownership model.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  imem_address;
  logic         imem_action_stb, imem_action_cyc;
  logic [15:0]  dmem_address, dmem_wdata;
  logic         dmem_action_stb, dmem_action_cyc, dmem_write;
  logic [1:0]   dmem_byte_enable;
  logic [127:0] mem_rdata;
  logic         mem_resp, mem_retry;

  logic [127:0] rr_imem_rdata, rr_dmem_rdata, fp_imem_rdata, fp_dmem_rdata;
  logic         rr_imem_resp, rr_imem_retry, rr_dmem_resp, rr_dmem_retry;
  logic         fp_imem_resp, fp_imem_retry, fp_dmem_resp, fp_dmem_retry;
  logic [15:0]  rr_mem_address, rr_mem_wdata, fp_mem_address, fp_mem_wdata;
  logic [1:0]   rr_mem_byte_enable, fp_mem_byte_enable;
  logic         rr_mem_write, rr_mem_action_stb, rr_mem_action_cyc;
  logic         fp_mem_write, fp_mem_action_stb, fp_mem_action_cyc;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset),
    .imem_address(imem_address), .imem_action_stb(imem_action_stb),
    .imem_action_cyc(imem_action_cyc), .imem_rdata(rr_imem_rdata),
    .imem_resp(rr_imem_resp), .imem_retry(rr_imem_retry),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_action_stb(dmem_action_stb), .dmem_action_cyc(dmem_action_cyc),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(rr_dmem_rdata), .dmem_resp(rr_dmem_resp), .dmem_retry(rr_dmem_retry),
    .mem_address(rr_mem_address), .mem_wdata(rr_mem_wdata),
    .mem_byte_enable(rr_mem_byte_enable), .mem_write(rr_mem_write),
    .mem_action_stb(rr_mem_action_stb), .mem_action_cyc(rr_mem_action_cyc),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_retry(mem_retry)
  );

  mem_port_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .imem_address(imem_address), .imem_action_stb(imem_action_stb),
    .imem_action_cyc(imem_action_cyc), .imem_rdata(fp_imem_rdata),
    .imem_resp(fp_imem_resp), .imem_retry(fp_imem_retry),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_action_stb(dmem_action_stb), .dmem_action_cyc(dmem_action_cyc),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(fp_dmem_rdata), .dmem_resp(fp_dmem_resp), .dmem_retry(fp_dmem_retry),
    .mem_address(fp_mem_address), .mem_wdata(fp_mem_wdata),
    .mem_byte_enable(fp_mem_byte_enable), .mem_write(fp_mem_write),
    .mem_action_stb(fp_mem_action_stb), .mem_action_cyc(fp_mem_action_cyc),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_retry(mem_retry)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 imem, 2 dmem) and whether dmem won last.
  int own_rr = 0, own_fp = 0;
  bit last_d_rr = 1'b0, last_d_fp = 1'b0;

  function automatic int next_owner(input int own, input bit last_d, input bit fixed);
    bit ri, rd;
    ri = imem_action_stb && imem_action_cyc;
    rd = dmem_action_stb && dmem_action_cyc;
    if (own == 0) begin
      if (ri && rd) return (fixed || !last_d) ? 2 : 1;
      if (rd) return 2;
      if (ri) return 1;
      return 0;
    end
    if (mem_resp || mem_retry) return 0;
    if (own == 1 && !imem_action_cyc) return 0;
    if (own == 2 && !dmem_action_cyc) return 0;
    return own;
  endfunction

  function automatic bit next_last_d(input int own, input bit last_d);
    if (own != 0 && (mem_resp || mem_retry)) return own == 2;
    return last_d;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      own_rr <= 0; own_fp <= 0; last_d_rr <= 1'b0; last_d_fp <= 1'b0;
    end else begin
      own_rr    <= next_owner(own_rr, last_d_rr, 1'b0);
      own_fp    <= next_owner(own_fp, last_d_fp, 1'b1);
      last_d_rr <= next_last_d(own_rr, last_d_rr);
      last_d_fp <= next_last_d(own_fp, last_d_fp);
    end
  end

  task automatic check_dut(input string tag, input int own,
      input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
      input logic w, input logic stb, input logic cyc,
      input logic ir, input logic irt, input logic [127:0] ird,
      input logic dr, input logic drt, input logic [127:0] drd);
    logic [15:0] ea, ewd;
    logic [1:0]  ebe;
    logic        ew, estb, ecyc, eir, eirt, edr, edrt;
    ea = '0; ewd = '0; ebe = '0; ew = 1'b0; estb = 1'b0; ecyc = 1'b0;
    eir = 1'b0; eirt = 1'b0; edr = 1'b0; edrt = 1'b0;
    if (!reset && own == 1) begin
      ea = imem_address; ebe = 2'b11; estb = imem_action_stb; ecyc = imem_action_cyc;
      eir = mem_resp; eirt = mem_retry && !mem_resp;
    end else if (!reset && own == 2) begin
      ea = dmem_address; ewd = dmem_wdata; ebe = dmem_byte_enable; ew = dmem_write;
      estb = dmem_action_stb; ecyc = dmem_action_cyc;
      edr = mem_resp; edrt = mem_retry && !mem_resp;
    end
    chk({tag, ".mem_address"},     128'(a),    128'(ea));
    chk({tag, ".mem_wdata"},       128'(wd),   128'(ewd));
    chk({tag, ".mem_byte_enable"}, 128'(be),   128'(ebe));
    chk({tag, ".mem_write"},       128'(w),    128'(ew));
    chk({tag, ".mem_action_stb"},  128'(stb),  128'(estb));
    chk({tag, ".mem_action_cyc"},  128'(cyc),  128'(ecyc));
    chk({tag, ".imem_resp"},       128'(ir),   128'(eir));
    chk({tag, ".imem_retry"},      128'(irt),  128'(eirt));
    chk({tag, ".dmem_resp"},       128'(dr),   128'(edr));
    chk({tag, ".dmem_retry"},      128'(drt),  128'(edrt));
    chk({tag, ".imem_rdata"},      ird,        mem_rdata);
    chk({tag, ".dmem_rdata"},      drd,        mem_rdata);
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_dut("rr", own_rr, rr_mem_address, rr_mem_wdata, rr_mem_byte_enable,
                rr_mem_write, rr_mem_action_stb, rr_mem_action_cyc,
                rr_imem_resp, rr_imem_retry, rr_imem_rdata,
                rr_dmem_resp, rr_dmem_retry, rr_dmem_rdata);
      check_dut("fp", own_fp, fp_mem_address, fp_mem_wdata, fp_mem_byte_enable,
                fp_mem_write, fp_mem_action_stb, fp_mem_action_cyc,
                fp_imem_resp, fp_imem_retry, fp_imem_rdata,
                fp_dmem_resp, fp_dmem_retry, fp_dmem_rdata);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_all();
    imem_action_stb = 1'b0; imem_action_cyc = 1'b0;
    dmem_action_stb = 1'b0; dmem_action_cyc = 1'b0;
    mem_resp = 1'b0; mem_retry = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    next();
    reset = 1'b0;
  endtask

  task automatic set_dmem(input logic [15:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input logic w);
    dmem_address = a; dmem_wdata = wd; dmem_byte_enable = be; dmem_write = w;
    dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1;
  endtask

  task automatic set_imem(input logic [15:0] a);
    imem_address = a; imem_action_stb = 1'b1; imem_action_cyc = 1'b1;
  endtask

  int d_grants;

  initial begin
    reset = 1'b1;
    imem_address = '0; dmem_address = '0; dmem_wdata = '0;
    dmem_byte_enable = '0; dmem_write = 1'b0; mem_rdata = '0;
    idle_all();
    next();
    started = 1'b1;
    mid();
    chk("reset_mem_stb", 128'(rr_mem_action_stb), 128'd0);
    chk("reset_imem_resp", 128'(rr_imem_resp), 128'd0);

    // Solo imem fetch, address change mid-transaction, resp on cycle 3.
    do_reset();
    set_imem(16'h0040);
    mid(); chk("a_c0_stb", 128'(rr_mem_action_stb), 128'd0);
    next();
    mid();
    chk("a_c1_stb",  128'(rr_mem_action_stb), 128'd1);
    chk("a_c1_addr", 128'(rr_mem_address), 128'h0040);
    chk("a_c1_wr",   128'(rr_mem_write), 128'd0);
    chk("a_c1_be",   128'(rr_mem_byte_enable), 128'd3);
    next();
    imem_address = 16'h0044;
    mid(); chk("a_c2_addr", 128'(rr_mem_address), 128'h0044);
    next();
    mem_rdata = 128'h0123_4567_89AB_CDEF_0000_1111_2222_BEEF;
    mem_resp = 1'b1;
    mid();
    chk("a_c3_resp",  128'(rr_imem_resp), 128'd1);
    chk("a_c3_rdata", rr_imem_rdata, 128'h0123_4567_89AB_CDEF_0000_1111_2222_BEEF);
    next();
    mem_resp = 1'b0; imem_action_stb = 1'b0; imem_action_cyc = 1'b0;
    mid(); chk("a_c4_idle", 128'(rr_mem_action_cyc), 128'd0);
    next();

    // Contention: round-robin alternates D, I, D; fixed priority stays on D.
    do_reset();
    set_imem(16'h0080);
    set_dmem(16'h1000, 16'h5A5A, 2'b01, 1'b1);
    next();
    mem_resp = 1'b1;
    mid();
    chk("b_c1_addr",  128'(rr_mem_address), 128'h1000);
    chk("b_c1_wr",    128'(rr_mem_write), 128'd1);
    chk("b_c1_wdata", 128'(rr_mem_wdata), 128'h5A5A);
    chk("b_c1_be",    128'(rr_mem_byte_enable), 128'd1);
    chk("b_c1_dresp", 128'(rr_dmem_resp), 128'd1);
    chk("b_c1_iresp", 128'(rr_imem_resp), 128'd0);
    next();
    mem_resp = 1'b0;
    mid(); chk("b_c2_turnaround", 128'(rr_mem_action_stb), 128'd0);
    next();
    mem_resp = 1'b1;
    mid();
    chk("b_c3_rr_addr", 128'(rr_mem_address), 128'h0080);
    chk("b_c3_fp_addr", 128'(fp_mem_address), 128'h1000);
    next();
    mem_resp = 1'b0;
    next();
    mem_resp = 1'b1;
    mid(); chk("b_c5_rr_addr", 128'(rr_mem_address), 128'h1000);
    next();
    d_grants = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (fp_dmem_resp === 1'b1) d_grants++;
      chk("b_fp_no_imem", 128'(fp_imem_resp), 128'd0);
      next();
    end
    chk("b_fp_d_grants", 128'(d_grants), 128'd4);
    dmem_action_stb = 1'b0; dmem_action_cyc = 1'b0; mem_resp = 1'b0;
    next();
    mid();
    chk("b_fp_i_addr", 128'(fp_mem_address), 128'h0080);
    chk("b_fp_i_wr",   128'(fp_mem_write), 128'd0);
    next();

    // Retry on imem while dmem waits; then resp+retry together on dmem.
    do_reset();
    set_imem(16'h0200);
    next();
    set_dmem(16'h3000, 16'h0000, 2'b11, 1'b0);
    mid(); chk("c_c1_addr", 128'(rr_mem_address), 128'h0200);
    next();
    mem_retry = 1'b1;
    mid();
    chk("c_c2_iretry", 128'(rr_imem_retry), 128'd1);
    chk("c_c2_dretry", 128'(rr_dmem_retry), 128'd0);
    chk("c_c2_iresp",  128'(rr_imem_resp), 128'd0);
    next();
    mem_retry = 1'b0;
    mid();
    chk("c_c3_iretry", 128'(rr_imem_retry), 128'd0);
    chk("c_c3_idle",   128'(rr_mem_action_stb), 128'd0);
    next();
    mem_resp = 1'b1; mem_retry = 1'b1;
    mid();
    chk("c_c4_addr",   128'(rr_mem_address), 128'h3000);
    chk("c_c4_dresp",  128'(rr_dmem_resp), 128'd1);
    chk("c_c4_dretry", 128'(rr_dmem_retry), 128'd0);
    next();
    mem_resp = 1'b0; mem_retry = 1'b0;
    next();
    mid(); chk("c_c6_addr", 128'(rr_mem_address), 128'h0200);
    next();

    // Reset mid-transaction, then a stray resp while idle.
    do_reset();
    set_dmem(16'h4000, 16'h1234, 2'b10, 1'b1);
    next();
    mid(); chk("d_c1_stb", 128'(rr_mem_action_stb), 128'd1);
    next();
    reset = 1'b1;
    mid();
    chk("d_c2_stb",  128'(rr_mem_action_stb), 128'd0);
    chk("d_c2_addr", 128'(rr_mem_address), 128'd0);
    next();
    reset = 1'b0; mem_resp = 1'b1;
    mid();
    chk("d_c3_stb",   128'(rr_mem_action_stb), 128'd0);
    chk("d_c3_addr",  128'(rr_mem_address), 128'd0);
    chk("d_c3_wr",    128'(rr_mem_write), 128'd0);
    chk("d_c3_dresp", 128'(rr_dmem_resp), 128'd0);
    next();
    mem_resp = 1'b0;
    next();

    // dmem aborts; pending imem is granted afterwards.
    do_reset();
    set_dmem(16'h5000, 16'h0000, 2'b11, 1'b0);
    next();
    set_imem(16'h0300);
    mid(); chk("e_c1_addr", 128'(rr_mem_address), 128'h5000);
    next();
    dmem_action_stb = 1'b0; dmem_action_cyc = 1'b0;
    mid();
    chk("e_c2_cyc", 128'(rr_mem_action_cyc), 128'd0);
    chk("e_c2_stb", 128'(rr_mem_action_stb), 128'd0);
    next();
    mid(); chk("e_c3_idle", 128'(rr_mem_action_stb), 128'd0);
    next();
    mem_resp = 1'b1;
    mid();
    chk("e_c4_rr_addr", 128'(rr_mem_address), 128'h0300);
    chk("e_c4_fp_addr", 128'(fp_mem_address), 128'h0300);
    chk("e_c4_iresp",   128'(rr_imem_resp), 128'd1);
    next();
    idle_all();
    next();
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
